// File: rtl/jtag_debug_bridge.sv
// Virtual-JTAG to 32-bit bus bridge: IDCODE/ADDR/WRITE/READ data registers feeding a single-outstanding bus master.
// Optional feature: define JTAG_ADDR_AUTOINC_EN to post-increment addr by 4 on each completed bus access.
module jtag_debug_bridge #(
  parameter logic [31:0] IDCODE = 32'h2573_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tdi,
  output logic        tdo,
  input  logic [1:0]  ir_in,
  output logic [1:0]  ir_out,
  input  logic        virtual_state_cdr,
  input  logic        virtual_state_sdr,
  input  logic        virtual_state_udr,
  input  logic        virtual_state_uir,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [1:0] IR_IDCODE = 2'd0;
  localparam logic [1:0] IR_ADDR   = 2'd1;
  localparam logic [1:0] IR_WRITE  = 2'd2;
  localparam logic [1:0] IR_READ   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] sr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        overrun_q;
  logic        we_q;
  logic        re_q;

  logic        idle;
  logic        wr_issue;
  logic        rd_issue;
  logic        addr_upd;
  logic [31:0] capture_d;
  logic [31:0] sr_d;
  logic [31:0] addr_inc_d;

  assign idle     = (state_q == IDLE);
  assign wr_issue = virtual_state_udr && (ir_in == IR_WRITE);
  assign rd_issue = (virtual_state_udr || virtual_state_uir) && (ir_in == IR_READ);
  assign addr_upd = virtual_state_udr && (ir_in == IR_ADDR);

  assign addr_inc_d = addr_q + 32'd4;

  always_comb begin
    capture_d = IDCODE;
    case (ir_in)
      IR_IDCODE: capture_d = IDCODE;
      IR_ADDR:   capture_d = addr_q;
      IR_WRITE:  capture_d = wdata_q;
      IR_READ:   capture_d = rdata_q;
      default:   capture_d = IDCODE;
    endcase
  end

  always_comb begin
    sr_d = sr_q;
    if (virtual_state_cdr)      sr_d = capture_d;
    else if (virtual_state_sdr) sr_d = {tdi, sr_q[31:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      overrun_q <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
    end else begin
      sr_q <= sr_d;

      case (state_q)
        IDLE: begin
          if (wr_issue) begin
            wdata_q <= sr_q;
            state_q <= WR;
            we_q    <= 1'b1;
          end else if (rd_issue) begin
            state_q <= RD;
            re_q    <= 1'b1;
          end
        end
        WR, RD: begin
          if (bus_ack) begin
            if (state_q == RD) rdata_q <= bus_rdata;
`ifdef JTAG_ADDR_AUTOINC_EN
            addr_q <= addr_inc_d;
`endif
            state_q <= IDLE;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          we_q    <= 1'b0;
          re_q    <= 1'b0;
        end
      endcase

      // Issues arriving while a request is pending (ack cycle included) are dropped.
      if ((wr_issue || rd_issue) && !idle) overrun_q <= 1'b1;

      // addr is frozen while a request is pending so bus_addr stays stable.
      if (addr_upd) begin
        overrun_q <= 1'b0;
        if (idle) addr_q <= sr_q;
      end
    end
  end

`ifndef JTAG_ADDR_AUTOINC_EN
  logic unused_inc;
  assign unused_inc = ^addr_inc_d;
`endif

  assign tdo       = sr_q[0];
  assign ir_out    = {overrun_q, ~idle};
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_we    = we_q;
  assign bus_re    = re_q;

endmodule

// File: tb/tb_jtag_debug_bridge.sv
// Directed self-checking bench for jtag_debug_bridge: IDCODE scan, write, read, overrun, reset and ack collision.
module tb_jtag_debug_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        tdi;
  logic        tdo;
  logic [1:0]  ir_in;
  logic [1:0]  ir_out;
  logic        cdr, sdr, udr, uir;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, bus_re, bus_ack;

  int checks = 0;
  int errors = 0;
  int wr_done = 0;

  jtag_debug_bridge dut (
    .clk               (clk),
    .rst               (rst),
    .tdi               (tdi),
    .tdo               (tdo),
    .ir_in             (ir_in),
    .ir_out            (ir_out),
    .virtual_state_cdr (cdr),
    .virtual_state_sdr (sdr),
    .virtual_state_udr (udr),
    .virtual_state_uir (uir),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_we            (bus_we),
    .bus_re            (bus_re),
    .bus_rdata         (bus_rdata),
    .bus_ack           (bus_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus_we && bus_ack) wr_done++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture, shift 32 bits of din in, return the 32 bits shifted out; optional update.
  task automatic dr_scan(input logic [1:0] ir, input logic [31:0] din, input bit upd,
                         output logic [31:0] dout);
    ir_in = ir;
    cdr = 1'b1;
    tick();
    cdr = 1'b0;
    sdr = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dout[i] = tdo;
      tdi = din[i];
      tick();
    end
    sdr = 1'b0;
    tdi = 1'b0;
    if (upd) begin
      udr = 1'b1;
      tick();
      udr = 1'b0;
    end
  endtask

  task automatic read_uir();
    ir_in = 2'd3;
    uir = 1'b1;
    tick();
    uir = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (ir_out !== 2'b00) begin errors++; $display("FAIL reset_ir_out got %b want 00", ir_out); end
    checks++;
    if ({bus_we, bus_re, tdo} !== 3'b000) begin errors++; $display("FAIL reset_outs got %b want 000", {bus_we, bus_re, tdo}); end
    dr_scan(2'd0, 32'h0, 1'b1, got);
    checks++;
    if (got !== 32'h2573_0001) begin errors++; $display("FAIL idcode got %h want 25730001", got); end
    checks++;
    if ({ir_out, bus_we, bus_re} !== 4'b0000) begin errors++; $display("FAIL idcode_side got %b want 0000", {ir_out, bus_we, bus_re}); end
  endtask

  task automatic test_write();
    logic [31:0] got, exp_addr;
    dr_scan(2'd1, 32'h0000_1000, 1'b1, got);
    dr_scan(2'd2, 32'hDEAD_BEEF, 1'b1, got);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({bus_we, bus_re} !== 2'b10) begin errors++; $display("FAIL wr_we c%0d got %b want 10", c, {bus_we, bus_re}); end
      checks++;
      if (bus_addr !== 32'h1000) begin errors++; $display("FAIL wr_addr c%0d got %h want 00001000", c, bus_addr); end
      checks++;
      if (bus_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_data c%0d got %h want deadbeef", c, bus_wdata); end
      if (c == 2) bus_ack = 1'b1;
      tick();
    end
    bus_ack = 1'b0;
    checks++;
    if ({bus_we, ir_out} !== 3'b000) begin errors++; $display("FAIL wr_done got %b want 000", {bus_we, ir_out}); end
`ifdef JTAG_ADDR_AUTOINC_EN
    exp_addr = 32'h0000_1004;
`else
    exp_addr = 32'h0000_1000;
`endif
    dr_scan(2'd1, 32'h0, 1'b0, got);
    checks++;
    if (got !== exp_addr) begin errors++; $display("FAIL wr_addr_after got %h want %h", got, exp_addr); end
  endtask

  task automatic test_read();
    logic [31:0] got, exp_addr;
    dr_scan(2'd1, 32'hFFFF_FFFC, 1'b1, got);
    read_uir();
    checks++;
    if ({bus_we, bus_re, ir_out} !== 4'b0101) begin errors++; $display("FAIL rd_req got %b want 0101", {bus_we, bus_re, ir_out}); end
    checks++;
    if (bus_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rd_addr got %h want fffffffc", bus_addr); end
    bus_rdata = 32'h1234_5678;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    checks++;
    if (bus_re !== 1'b0) begin errors++; $display("FAIL rd_done got %b want 0", bus_re); end
    dr_scan(2'd3, 32'h0, 1'b0, got);
    checks++;
    if (got !== 32'h1234_5678) begin errors++; $display("FAIL rd_data got %h want 12345678", got); end
`ifdef JTAG_ADDR_AUTOINC_EN
    exp_addr = 32'h0;
`else
    exp_addr = 32'hFFFF_FFFC;
`endif
    dr_scan(2'd1, 32'h0, 1'b0, got);
    checks++;
    if (got !== exp_addr) begin errors++; $display("FAIL rd_addr_after got %h want %h", got, exp_addr); end
  endtask

  task automatic test_overrun();
    logic [31:0] got;
    int wr0;
    dr_scan(2'd1, 32'h0000_2000, 1'b1, got);
    wr0 = wr_done;
    dr_scan(2'd2, 32'h1111_1111, 1'b1, got);
    checks++;
    if (ir_out !== 2'b01) begin errors++; $display("FAIL ov_busy got %b want 01", ir_out); end
    dr_scan(2'd2, 32'h2222_2222, 1'b1, got);
    checks++;
    if (ir_out !== 2'b11) begin errors++; $display("FAIL ov_flag got %b want 11", ir_out); end
    checks++;
    if (bus_wdata !== 32'h1111_1111) begin errors++; $display("FAIL ov_wdata got %h want 11111111", bus_wdata); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus_we, ir_out} !== 3'b010) begin errors++; $display("FAIL ov_after_ack got %b want 010", {bus_we, ir_out}); end
    checks++;
    if (wr_done - wr0 !== 1) begin errors++; $display("FAIL ov_wr_count got %0d want 1", wr_done - wr0); end
    dr_scan(2'd2, 32'h0, 1'b0, got);
    checks++;
    if (got !== 32'h1111_1111) begin errors++; $display("FAIL ov_wdata_scan got %h want 11111111", got); end
    dr_scan(2'd1, 32'h0000_3000, 1'b1, got);
    checks++;
    if (ir_out !== 2'b00) begin errors++; $display("FAIL ov_clear got %b want 00", ir_out); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] got;
    read_uir();
    checks++;
    if (bus_re !== 1'b1) begin errors++; $display("FAIL rst_rd_req got %b want 1", bus_re); end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_we, bus_re, tdo, ir_out} !== 5'b0) begin errors++; $display("FAIL rst_async got %b want 00000", {bus_we, bus_re, tdo, ir_out}); end
    checks++;
    if ({bus_addr, bus_wdata} !== 64'h0) begin errors++; $display("FAIL rst_bus got %h want 0", {bus_addr, bus_wdata}); end
    tick();
    rst = 1'b0;
    tick();
    bus_rdata = 32'hAAAA_5555;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    checks++;
    if ({bus_re, bus_we, ir_out} !== 4'b0) begin errors++; $display("FAIL rst_late_ack got %b want 0000", {bus_re, bus_we, ir_out}); end
    dr_scan(2'd3, 32'h0, 1'b0, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", got); end
  endtask

  task automatic test_ack_collision();
    logic [31:0] got, exp_addr;
    dr_scan(2'd1, 32'h0000_4000, 1'b1, got);
    read_uir();
    dr_scan(2'd2, 32'h5555_5555, 1'b0, got);
    ir_in = 2'd2;
    udr = 1'b1;
    bus_ack = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    tick();
    udr = 1'b0;
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    checks++;
    if ({bus_we, bus_re, ir_out} !== 4'b0010) begin errors++; $display("FAIL col_state got %b want 0010", {bus_we, bus_re, ir_out}); end
    tick();
    checks++;
    if (bus_we !== 1'b0) begin errors++; $display("FAIL col_no_write got %b want 0", bus_we); end
    dr_scan(2'd3, 32'h0, 1'b0, got);
    checks++;
    if (got !== 32'hCAFE_F00D) begin errors++; $display("FAIL col_rdata got %h want cafef00d", got); end
    dr_scan(2'd2, 32'h0, 1'b0, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL col_wdata got %h want 0", got); end
`ifdef JTAG_ADDR_AUTOINC_EN
    exp_addr = 32'h0000_4004;
`else
    exp_addr = 32'h0000_4000;
`endif
    dr_scan(2'd1, 32'h0, 1'b0, got);
    checks++;
    if (got !== exp_addr) begin errors++; $display("FAIL col_addr got %h want %h", got, exp_addr); end
  endtask

  initial begin
    rst = 1'b1;
    tdi = 1'b0;
    ir_in = 2'd0;
    cdr = 1'b0;
    sdr = 1'b0;
    udr = 1'b0;
    uir = 1'b0;
    bus_rdata = 32'h0;
    bus_ack = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_overrun();
    test_reset_mid_read();
    test_ack_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
